lcd_hd44780_ctrl: RTL and testbench

Parametrised Avalon-MM slave driving an HD44780/16207-style character LCD with generated bus timing. The previous LCD slave just passed bus strobes straight to the panel pins. This block adds:
- address-setup, enable-pulse and hold phases counted in clock cycles;
- `waitrequest` back-pressure for the duration of each access;
- optional 4-bit (two-nibble) bus mode.

It sits between the system interconnect and the LCD pins in the SoPC top level.

---
 rtl/lcd_pkg.sv | 21 ++
 rtl/lcd_hd44780_ctrl_timer.sv | 27 ++
 rtl/lcd_hd44780_ctrl.sv | 128 ++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and helpers for the HD44780 character-LCD bus controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } lcd_state_t;

  // Width of a down-counter able to hold the longest of the three phases.
  function automatic int cnt_width(input int t_as, input int t_pw, input int t_h);
    int m;
    m = t_as;
    if (t_pw > m) m = t_pw;
    if (t_h > m) m = t_h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_timer.sv
// Loadable phase down-counter; done is high while the count sits at 1.
module lcd_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Avalon-MM slave generating HD44780 setup / enable / hold timing, 8- or 4-bit bus.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int T_AS   = 2,
  parameter int T_PW   = 4,
  parameter int T_H    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              waitrequest,
  output logic              LCD_E,
  output logic              LCD_RS,
  output logic              LCD_RW,
  inout  wire  [DATA_W-1:0] LCD_data
);

  localparam int CNT_W = cnt_width(T_AS, T_PW, T_H);

  lcd_state_t       state_q, state_d;
  logic             nib_q, nib_d;
  logic             e_q, rs_q, rw_q, is_rd_q;
  logic [7:0]       wd_q, rd_q;
  logic             accept, sample, drive;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic [DATA_W-1:0] drv, bus_in;

  lcd_phase_timer #(.W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    nib_d    = nib_q;
    accept   = 1'b0;
    sample   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: if (read || write) begin
        accept   = 1'b1;
        nib_d    = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_AS);
        state_d  = SETUP;
      end
      SETUP: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_PW);
        state_d  = PULSE;
      end
      PULSE: if (tmr_done) begin
        sample   = is_rd_q;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_H);
        state_d  = HOLD;
      end
      HOLD: if (tmr_done) begin
        if (DATA_W == 4 && !nib_q) begin
          nib_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_AS);
          state_d  = SETUP;
        end else begin
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // E is registered from the next state, so it is high exactly while in PULSE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      nib_q   <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      is_rd_q <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      e_q     <= (state_d == PULSE);
      if (accept) begin
        rs_q    <= address[1];
        rw_q    <= address[0];
        is_rd_q <= read;
        wd_q    <= writedata;
      end
      if (sample) begin
        if (DATA_W == 8) rd_q <= 8'(bus_in);
        else if (!nib_q) rd_q[7:4] <= bus_in[3:0];
        else rd_q[3:0] <= bus_in[3:0];
      end
    end
  end

  always_comb begin
    drv = DATA_W'(wd_q);
    if (DATA_W == 4) drv = DATA_W'(nib_q ? wd_q[3:0] : wd_q[7:4]);
  end

  assign drive       = !rw_q && (state_q == SETUP || state_q == PULSE || state_q == HOLD);
  assign LCD_data    = drive ? drv : {DATA_W{1'bz}};
  assign bus_in      = LCD_data;
  assign LCD_E       = e_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = rw_q;
  assign readdata    = rd_q;
  assign waitrequest = (read || write) && (state_q != DONE);

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomised bench for lcd_hd44780_ctrl: three instances (8-bit, 4-bit, minimum timing).
module tb_lcd_hd44780_ctrl;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic       wt;
    logic [7:0] bus;
    logic [7:0] rd;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       rd_i [3];
  logic       wr_i [3];
  logic [1:0] addr_i [3];
  logic [7:0] wd_i [3];
  logic       e_o [3];
  logic       rs_o [3];
  logic       rw_o [3];
  logic       wt_o [3];
  logic [7:0] rdd_o [3];
  logic [7:0] pv [3];

  // Undriven panel bus floats high; panel drives only while E is high on a read.
  tri1 [7:0] bus0;
  tri1 [3:0] bus1;
  tri1 [7:0] bus2;
  assign bus0 = (e_o[0] && rw_o[0]) ? pv[0] : 8'hzz;
  assign bus1 = (e_o[1] && rw_o[1]) ? pv[1][3:0] : 4'hz;
  assign bus2 = (e_o[2] && rw_o[2]) ? pv[2] : 8'hzz;

  lcd_hd44780_ctrl u_dut8 (
    .clk(clk), .reset_n(reset_n), .address(addr_i[0]), .read(rd_i[0]), .write(wr_i[0]),
    .writedata(wd_i[0]), .readdata(rdd_o[0]), .waitrequest(wt_o[0]),
    .LCD_E(e_o[0]), .LCD_RS(rs_o[0]), .LCD_RW(rw_o[0]), .LCD_data(bus0)
  );

  lcd_hd44780_ctrl #(.DATA_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(addr_i[1]), .read(rd_i[1]), .write(wr_i[1]),
    .writedata(wd_i[1]), .readdata(rdd_o[1]), .waitrequest(wt_o[1]),
    .LCD_E(e_o[1]), .LCD_RS(rs_o[1]), .LCD_RW(rw_o[1]), .LCD_data(bus1)
  );

  lcd_hd44780_ctrl #(.DATA_W(8), .T_AS(1), .T_PW(1), .T_H(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(addr_i[2]), .read(rd_i[2]), .write(wr_i[2]),
    .writedata(wd_i[2]), .readdata(rdd_o[2]), .waitrequest(wt_o[2]),
    .LCD_E(e_o[2]), .LCD_RS(rs_o[2]), .LCD_RW(rw_o[2]), .LCD_data(bus2)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  obs_t       trace [64];
  logic [7:0] last_rd [3];

  function automatic int nib_cnt(input int id); return (id == 1) ? 2 : 1; endfunction
  function automatic int tas(input int id);     return (id == 2) ? 1 : 2; endfunction
  function automatic int tpw(input int id);     return (id == 2) ? 1 : 4; endfunction
  function automatic int th(input int id);      return (id == 2) ? 1 : 3; endfunction
  function automatic int period(input int id);  return tas(id) + tpw(id) + th(id); endfunction
  function automatic int done_cyc(input int id); return 1 + nib_cnt(id) * period(id); endfunction

  // Value on the panel pins for transfer k of a byte: whole byte, or high then low nibble.
  function automatic logic [7:0] lane(input int id, input int k, input logic [7:0] b);
    if (nib_cnt(id) == 1) return b;
    return (k == 0) ? {4'h0, b[7:4]} : {4'h0, b[3:0]};
  endfunction

  function automatic obs_t observe(input int id);
    obs_t o;
    o.e  = e_o[id];
    o.rs = rs_o[id];
    o.rw = rw_o[id];
    o.wt = wt_o[id];
    o.rd = rdd_o[id];
    case (id)
      0:       o.bus = bus0;
      1:       o.bus = {4'h0, bus1};
      default: o.bus = bus2;
    endcase
    return o;
  endfunction

  // Expected pins at cycle c of an access whose request is first seen at cycle 0.
  task automatic model(input int id, input int c, input logic is_rd, input logic [1:0] addr,
                       input logic [7:0] wd, input logic [7:0] pb, input logic [7:0] prev,
                       output obs_t exp, output obs_t msk);
    int p, dn, k, off;
    logic [7:0] pulled;
    p      = period(id);
    dn     = done_cyc(id);
    pulled = (id == 1) ? 8'h0F : 8'hFF;
    exp    = '0;
    msk    = '1;
    if (c == 0) begin
      exp.wt  = 1'b1;
      exp.bus = pulled;
      msk.rs  = 1'b0;
      msk.rw  = 1'b0;
      msk.rd  = '0;
    end else if (c < dn) begin
      k      = (c - 1) / p;
      off    = (c - 1) % p;
      exp.e  = (off >= tas(id)) && (off < tas(id) + tpw(id));
      exp.rs = addr[1];
      exp.rw = addr[0];
      exp.wt = 1'b1;
      msk.rd = '0;
      if (!addr[0])   exp.bus = lane(id, k, wd);
      else if (exp.e) exp.bus = lane(id, k, pb);
      else            exp.bus = pulled;
    end else begin
      exp.bus = pulled;
      exp.rd  = is_rd ? pb : prev;
      msk.rs  = 1'b0;
      msk.rw  = 1'b0;
    end
  endtask

  // Issue one access on instance id, record pins every cycle through DONE, then release.
  task automatic drive_access(input int id, input logic rd, input logic wr, input logic [1:0] addr,
                              input logic [7:0] wd, input logic [7:0] pb);
    int p, dn;
    p  = period(id);
    dn = done_cyc(id);
    rd_i[id]   = rd;
    wr_i[id]   = wr;
    addr_i[id] = addr;
    wd_i[id]   = wd;
    for (int c = 0; c <= dn; c++) begin
      pv[id] = lane(id, (c == 0) ? 0 : (c - 1) / p, pb);
      #1;
      trace[c] = observe(id);
      if (c == dn) begin
        rd_i[id] = 1'b0;
        wr_i[id] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      obs_t o, want;
      o = observe(id);
      want = '{e: 1'b0, rs: 1'b0, rw: 1'b1, wt: 1'b0, bus: (id == 1) ? 8'h0F : 8'hFF, rd: 8'h00};
      n_checks++;
      if (o !== want) begin
        n_fail++;
        $display("FAIL reset dut%0d: got {e,rs,rw,wait,bus,rd}=%h expected %h", id, o, want);
      end
      last_rd[id] = 8'h00;
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write8();
    obs_t exp, msk;
    drive_access(0, 1'b0, 1'b1, 2'd2, 8'h41, 8'h00);
    for (int c = 0; c <= done_cyc(0); c++) begin
      model(0, c, 1'b0, 2'd2, 8'h41, 8'h00, last_rd[0], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL write8 cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
  endtask

  task automatic test_read8();
    obs_t exp, msk;
    drive_access(0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h80);
    for (int c = 0; c <= done_cyc(0); c++) begin
      model(0, c, 1'b1, 2'd3, 8'h00, 8'h80, last_rd[0], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL read8 cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
    last_rd[0] = 8'h80;
  endtask

  task automatic test_write4();
    obs_t exp, msk;
    drive_access(1, 1'b0, 1'b1, 2'd0, 8'h38, 8'h00);
    for (int c = 0; c <= done_cyc(1); c++) begin
      model(1, c, 1'b0, 2'd0, 8'h38, 8'h00, last_rd[1], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL write4 cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
  endtask

  task automatic test_read4();
    obs_t exp, msk;
    drive_access(1, 1'b1, 1'b0, 2'd3, 8'h00, 8'hA5);
    for (int c = 0; c <= done_cyc(1); c++) begin
      model(1, c, 1'b1, 2'd3, 8'h00, 8'hA5, last_rd[1], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL read4 cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
    last_rd[1] = 8'hA5;
  endtask

  task automatic test_random();
    obs_t exp, msk;
    for (int i = 0; i < 24; i++) begin
      int         id, kind;
      logic       rd, wr;
      logic [1:0] addr;
      logic [7:0] wd, pb;
      id   = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 2));
      wd   = 8'($urandom);
      pb   = 8'($urandom);
      rd   = (kind != 0);
      wr   = (kind != 1);
      addr = {1'($urandom), rd};
      drive_access(id, rd, wr, addr, wd, pb);
      for (int c = 0; c <= done_cyc(id); c++) begin
        model(id, c, rd, addr, wd, pb, last_rd[id], exp, msk);
        n_checks++;
        if ((trace[c] & msk) !== (exp & msk)) begin
          n_fail++;
          $display("FAIL random#%0d dut%0d rd=%b wr=%b cycle %0d: got %h expected %h",
                   i, id, rd, wr, c, trace[c] & msk, exp & msk);
        end
      end
      if (rd) last_rd[id] = pb;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp, msk, o;
    logic [7:0] wd;
    wd = {1'b0, 7'($urandom)};
    wr_i[0] = 1'b1;
    rd_i[0] = 1'b0;
    addr_i[0] = 2'd2;
    wd_i[0] = wd;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (e_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: E got %b expected 1", e_o[0]);
    end
    reset_n = 1'b0;
    #1;
    o = observe(0);
    n_checks++;
    if ({o.e, o.rs, o.rw, o.bus} !== {1'b0, 1'b0, 1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_mid async: got {e,rs,rw,bus}=%h expected %h",
               {o.e, o.rs, o.rw, o.bus}, {1'b0, 1'b0, 1'b1, 8'hFF});
    end
    wr_i[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int id = 0; id < 3; id++) last_rd[id] = 8'h00;
    @(negedge clk);
    drive_access(0, 1'b0, 1'b1, 2'd0, wd, 8'h00);
    for (int c = 0; c <= done_cyc(0); c++) begin
      model(0, c, 1'b0, 2'd0, wd, 8'h00, last_rd[0], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL reset_mid after cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp, msk;
    logic [7:0] d0, d1;
    d0 = {1'b0, 7'($urandom)};
    d1 = {1'b0, 7'($urandom)};
    rd_i[2] = 1'b0;
    wr_i[2] = 1'b1;
    addr_i[2] = 2'd0;
    wd_i[2] = d0;
    for (int c = 0; c < 10; c++) begin
      #1;
      trace[c] = observe(2);
      if (c == 4) wd_i[2] = d1;
      if (c == 9) wr_i[2] = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 5) model(2, c, 1'b0, 2'd0, d0, 8'h00, last_rd[2], exp, msk);
      else       model(2, c - 5, 1'b0, 2'd0, d1, 8'h00, last_rd[2], exp, msk);
      n_checks++;
      if ((trace[c] & msk) !== (exp & msk)) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", c, trace[c] & msk, exp & msk);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int id = 0; id < 3; id++) begin
      rd_i[id]    = 1'b0;
      wr_i[id]    = 1'b0;
      addr_i[id]  = 2'd0;
      wd_i[id]    = 8'h00;
      pv[id]      = 8'h00;
      last_rd[id] = 8'h00;
    end
    @(negedge clk);
    test_reset();
    test_write8();
    test_read8();
    test_write4();
    test_read4();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
